imm_decode_stage: RTL and testbench
===================================

Name: imm_decode_stage

Overview:
- Registered immediate-decode pipeline stage for the RV core, placed between fetch and the execute/issue logic.
- Classifies every RV32I/RV64I base opcode into an instruction format and produces the sign-extended immediate at XLEN width.
- Uses a valid/ready handshake with a two-entry skid buffer, so it sustains one instruction per cycle under backpressure.
- Supports a synchronous flush for branch redirects.

Parameters:
- XLEN, 32, datapath/immediate width; legal values 32 or 64.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; drops all buffered entries
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept an instruction
- in_instr  in  32  raw instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded entry valid
- out_ready  in  1  downstream accepts
- out_instr  out  32  instruction passed through
- out_pc  out  XLEN  PC passed through
- out_imm  out  XLEN  decoded immediate
- out_fmt  out  3  0=R 1=I 2=S 3=B 4=U 5=J 6=Z(csr zimm) 7=illegal

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-low on rst_n. All state registers clear on rst_n low regardless of clk.
- Reset values: out_valid=0, in_ready=1, out_instr=0, out_pc=0, out_imm=0, out_fmt=0, skid entry invalid.
- Format decode, combinational on in_instr, registered on accept:
  - opcode[1:0]!=2'b11 -> illegal.
  - opcode[6:2] 01101 (LUI), 00101 (AUIPC) -> U.
  - 11011 (JAL) -> J.
  - 11001 (JALR), 00000 (LOAD), 00100 (OP-IMM), 00011 (MISC-MEM), 11100 (SYSTEM) -> I.
  - 00110 (OP-IMM-32) -> I when XLEN=64, illegal when XLEN=32.
  - 01000 (STORE) -> S.
  - 11000 (BRANCH) -> B.
  - 01100 (OP) -> R; 01110 (OP-32) -> R when XLEN=64, else illegal.
  - Anything else -> illegal.
- Immediate construction; all results sign-extended from instr[31] to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, upper bits sign-extended from instr[31] when XLEN=64.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R and illegal: imm=0. Illegal entries still propagate with fmt=7; they are not dropped.
- Latency: 1 cycle from in_valid&&in_ready to out_valid.
- Handshake:
  - A transfer occurs on valid&&ready at each side.
  - out_* hold stable while out_valid&&!out_ready.
  - in_ready is a register output with no combinational path from out_ready.
- Occupancy states (main register, skid register):
  - EMPTY: accept -> ONE.
  - ONE:
    - accept with output taken -> ONE, new entry in main.
    - accept without output taken -> TWO, new entry in skid.
    - no accept, output taken -> EMPTY.
  - TWO: in_ready=0. Output taken -> skid moves to main, state ONE, in_ready=1 next cycle.
- Ordering: strict FIFO; the skid entry never overtakes main.
- Flush: the next state is EMPTY with in_ready=1. It overrides a simultaneous accept (the input is dropped) and any simultaneous output transfer; downstream still counts that transfer.
- Reset mid-operation discards all entries immediately.

Optional Feature:
- Macro IMM_DECODE_ZICSR_EN.
- Defined: SYSTEM opcode with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) -> fmt=6 (Z), imm = zero-extended instr[19:15].
- Not defined: these encodings decode as I-format, imm = sign-extended instr[31:20]; fmt code 6 is never produced.

Test Plan:
- XLEN=32, in 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, fmt=1, imm=0xFFFFFFFF.
- in 0xFE112E23 (sw x1,-4(x2)) -> fmt=2, imm=0xFFFFFFFC. In 0x00000463 (beq +8) -> fmt=3, imm=0x00000008.
- in 0x800002B7 (lui x5,0x80000) -> XLEN=32 imm=0x80000000; XLEN=64 imm=0xFFFFFFFF80000000, fmt=4. In 0x0000007F -> fmt=7, imm=0.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles, two back-to-back instructions A,B presented.
  - Response: in_ready=0 from the cycle after B is accepted; out holds A.
  - Then out_ready=1 -> A then B on consecutive cycles, in_ready=1 the cycle after A leaves. No loss or duplication.
- Flush with state TWO and in_valid=1 -> next cycle out_valid=0, in_ready=1, the input is not captured. Assert rst_n low mid-stream -> out_valid=0 asynchronously.
- With IMM_DECODE_ZICSR_EN: in 0x0007D073 (csrrwi x0,0x0,15) -> fmt=6, imm=0x0000000F. Without the macro -> fmt=1, imm=0x00000000.

Source files
------------

// File: rtl/imm_decode_stage_if.sv
// Handshake bundle for imm_decode_stage: upstream instruction side and downstream decoded side.
// master = the agent feeding instructions and consuming decoded entries; slave = the stage itself.
interface imm_decode_stage_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;

   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_instr;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_fmt;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt
   );
endinterface

// File: rtl/imm_decode_stage.sv
// Registered RV32I/RV64I immediate-decode stage with a two-entry skid buffer and flush.
// Define IMM_DECODE_ZICSR_EN to decode CSR immediate forms as fmt Z (zero-extended zimm).
module imm_decode_stage #(
   parameter int XLEN = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   imm_decode_stage_if.slave   bus,
   output logic [1:0]          dbg_state
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_decode_stage: XLEN must be 32 or 64");
   end

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;
   localparam logic [2:0] FMT_Z = 3'd6;
   localparam logic [2:0] FMT_X = 3'd7;

   localparam logic [4:0] OP_LOAD     = 5'b00000;
   localparam logic [4:0] OP_MISC_MEM = 5'b00011;
   localparam logic [4:0] OP_OP_IMM   = 5'b00100;
   localparam logic [4:0] OP_AUIPC    = 5'b00101;
   localparam logic [4:0] OP_OP_IMM32 = 5'b00110;
   localparam logic [4:0] OP_STORE    = 5'b01000;
   localparam logic [4:0] OP_OP       = 5'b01100;
   localparam logic [4:0] OP_LUI      = 5'b01101;
   localparam logic [4:0] OP_OP32     = 5'b01110;
   localparam logic [4:0] OP_BRANCH   = 5'b11000;
   localparam logic [4:0] OP_JALR     = 5'b11001;
   localparam logic [4:0] OP_JAL      = 5'b11011;
   localparam logic [4:0] OP_SYSTEM   = 5'b11100;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Main register (visible on out_*) and skid register.
   logic [31:0]     m_instr, s_instr;
   logic [XLEN-1:0] m_pc,    s_pc;
   logic [XLEN-1:0] m_imm,   s_imm;
   logic [2:0]      m_fmt,   s_fmt;

   logic            accept, take;
   logic            ld_main_in, ld_main_skid, ld_skid;

   logic [31:0]     ins;
   logic [4:0]      op;
   logic [2:0]      dec_fmt;
   logic [XLEN-1:0] dec_imm;

   // ------------------------------------------------------------------
   // Format classification
   // ------------------------------------------------------------------
   assign ins = bus.in_instr;
   assign op  = ins[6:2];

   always_comb begin
      dec_fmt = FMT_X;
      if (ins[1:0] == 2'b11) begin
         unique case (op)
            OP_LUI, OP_AUIPC:                      dec_fmt = FMT_U;
            OP_JAL:                                dec_fmt = FMT_J;
            OP_JALR, OP_LOAD, OP_OP_IMM,
            OP_MISC_MEM:                           dec_fmt = FMT_I;
`ifdef IMM_DECODE_ZICSR_EN
            OP_SYSTEM:                             dec_fmt = ins[14] ? FMT_Z : FMT_I;
`else
            OP_SYSTEM:                             dec_fmt = FMT_I;
`endif
            OP_OP_IMM32:                           dec_fmt = (XLEN == 64) ? FMT_I : FMT_X;
            OP_STORE:                              dec_fmt = FMT_S;
            OP_BRANCH:                             dec_fmt = FMT_B;
            OP_OP:                                 dec_fmt = FMT_R;
            OP_OP32:                               dec_fmt = (XLEN == 64) ? FMT_R : FMT_X;
            default:                               dec_fmt = FMT_X;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Immediate construction; ins[31] is always the sign bit, so each
   // form replicates it over the bits above the encoded field.
   // ------------------------------------------------------------------
   always_comb begin
      dec_imm = '0;
      unique case (dec_fmt)
         FMT_I: dec_imm = {{(XLEN-11){ins[31]}}, ins[30:20]};
         FMT_S: dec_imm = {{(XLEN-11){ins[31]}}, ins[30:25], ins[11:7]};
         FMT_B: dec_imm = {{(XLEN-12){ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
         FMT_U: dec_imm = {{(XLEN-31){ins[31]}}, ins[30:12], 12'b0};
         FMT_J: dec_imm = {{(XLEN-20){ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
         FMT_Z: dec_imm = {{(XLEN-5){1'b0}}, ins[19:15]};
         default: dec_imm = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // Handshake: a transfer happens on a side when its valid and ready are
   // both high at a rising clk edge. in_ready and out_valid are decoded
   // only from the state register, so neither depends on out_ready or
   // in_valid in the same cycle; out_* come straight from the main register
   // and therefore stay stable while out_valid && !out_ready.
   // ------------------------------------------------------------------
   assign bus.in_ready  = (state != ST_TWO);
   assign bus.out_valid = (state != ST_EMPTY);
   assign bus.out_instr = m_instr;
   assign bus.out_pc    = m_pc;
   assign bus.out_imm   = m_imm;
   assign bus.out_fmt   = m_fmt;
   assign dbg_state     = state;

   assign accept = bus.in_valid  && bus.in_ready;
   assign take   = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      if (flush) begin
         // Flush wins over any accept or output transfer this cycle.
         state_nxt = ST_EMPTY;
      end else begin
         unique case (state)
            ST_EMPTY: begin
               if (accept) begin
                  ld_main_in = 1'b1;
                  state_nxt  = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && take) begin
                  ld_main_in = 1'b1;
               end else if (accept) begin
                  ld_skid    = 1'b1;
                  state_nxt  = ST_TWO;
               end else if (take) begin
                  state_nxt  = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (take) begin
                  ld_main_skid = 1'b1;
                  state_nxt    = ST_ONE;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Entry storage
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_instr <= '0;
         m_pc    <= '0;
         m_imm   <= '0;
         m_fmt   <= FMT_R;
      end else if (ld_main_in) begin
         m_instr <= bus.in_instr;
         m_pc    <= bus.in_pc;
         m_imm   <= dec_imm;
         m_fmt   <= dec_fmt;
      end else if (ld_main_skid) begin
         m_instr <= s_instr;
         m_pc    <= s_pc;
         m_imm   <= s_imm;
         m_fmt   <= s_fmt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_instr <= '0;
         s_pc    <= '0;
         s_imm   <= '0;
         s_fmt   <= FMT_R;
      end else if (ld_skid) begin
         s_instr <= bus.in_instr;
         s_pc    <= bus.in_pc;
         s_imm   <= dec_imm;
         s_fmt   <= dec_fmt;
      end
   end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: decode vectors, backpressure, flush and async reset,
// with an in-order scoreboard on every output transfer.
module tb_imm_decode_stage;

   localparam int XLEN = 32;
   localparam int W    = 32 + XLEN;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic            flush = 1'b0;
   logic [1:0]      dbg_state;
   logic [XLEN-1:0] pc_ctr = 'h1000;

   int              n_cmp = 0;
   int              n_err = 0;
   logic [W-1:0]    exp_q[$];

   imm_decode_stage_if #(.XLEN(XLEN)) bus ();

   imm_decode_stage #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   // Sampled on the falling edge: whatever handshake is visible now completes
   // at the next rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            check("sb_has_entry", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) check("sb_order", {bus.out_instr, bus.out_pc}, exp_q.pop_front());
         end
         if (flush) exp_q.delete();
         else if (bus.in_valid && bus.in_ready) exp_q.push_back({bus.in_instr, bus.in_pc});
      end
   end

   // ---------------- drivers ----------------
   task automatic drive_in(input logic v, input logic [31:0] instr, input logic [XLEN-1:0] pc);
      bus.in_valid = v;
      bus.in_instr = instr;
      bus.in_pc    = pc;
   endtask

   task automatic single(input string tag, input logic [31:0] instr,
                         input logic [2:0] fmt, input logic [XLEN-1:0] imm);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      drive_in(1'b1, instr, pc_ctr);
      pc_ctr = pc_ctr + 4;
      @(posedge clk); #1;
      drive_in(1'b0, 32'h0, '0);
      @(negedge clk);
      check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_fmt"},   64'(bus.out_fmt),   64'(fmt));
      check({tag, "_imm"},   64'(bus.out_imm),   64'(imm));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      drive_in(1'b0, 32'h0, '0);
      bus.out_ready = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready",  64'(bus.in_ready),  64'd1);
      check("rst_out_instr", 64'(bus.out_instr), 64'd0);
      check("rst_out_pc",    64'(bus.out_pc),    64'd0);
      check("rst_out_imm",   64'(bus.out_imm),   64'd0);
      check("rst_out_fmt",   64'(bus.out_fmt),   64'd0);
      check("rst_state",     64'(dbg_state),     64'd0);
      #2 rst_n = 1'b1;

      // Decode vectors
      single("addi_m1",  32'hFFF00093, 3'd1, 'hFFFFFFFF);
      single("sw_m4",    32'hFE112E23, 3'd2, 'hFFFFFFFC);
      single("beq_p8",   32'h00000463, 3'd3, 'h00000008);
      single("beq_m4",   32'hFE000EE3, 3'd3, 'hFFFFFFFC);
      single("lui",      32'h800002B7, 3'd4, (XLEN == 64) ? 64'hFFFFFFFF80000000 : 64'h80000000);
      single("auipc",    32'h00001517, 3'd4, 'h00001000);
      single("jal_p8",   32'h008000EF, 3'd5, 'h00000008);
      single("jalr_min", 32'h800000E7, 3'd1, 'hFFFFF800);
      single("add",      32'h002081B3, 3'd0, '0);
      single("bad_op",   32'h0000007F, 3'd7, '0);
      single("bad_lo",   32'hFFF00090, 3'd7, '0);
      single("addiw",    32'h0000001B, (XLEN == 64) ? 3'd1 : 3'd7, '0);
      single("csrrw",    32'h34029073, 3'd1, 'h00000340);
`ifdef IMM_DECODE_ZICSR_EN
      single("csrrwi",   32'h0007D073, 3'd6, 'h0000000F);
`else
      single("csrrwi",   32'h0007D073, 3'd1, 'h00000000);
`endif

      // Backpressure: A and B back-to-back with out_ready low for three cycles
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      drive_in(1'b1, 32'h00A00513, 'h2000);
      @(posedge clk); #1;
      drive_in(1'b1, 32'h00B00593, 'h2004);
      @(posedge clk); #1;
      drive_in(1'b0, 32'h0, '0);
      @(negedge clk);
      check("bp_in_ready_full", 64'(bus.in_ready),  64'd0);
      check("bp_hold_a",        64'(bus.out_instr), 64'h00A00513);
      check("bp_state_two",     64'(dbg_state),     64'd2);
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_hold_a_again",  64'(bus.out_instr), 64'h00A00513);
      check("bp_imm_a",         64'(bus.out_imm),   64'd10);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_b_next",        64'(bus.out_instr), 64'h00B00593);
      check("bp_imm_b",         64'(bus.out_imm),   64'd11);
      check("bp_in_ready_back", 64'(bus.in_ready),  64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_drained",       64'(bus.out_valid), 64'd0);

      // Flush in TWO with a simultaneous input and output transfer
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      drive_in(1'b1, 32'h00C00613, 'h3000);
      @(posedge clk); #1;
      drive_in(1'b1, 32'h00D00693, 'h3004);
      @(posedge clk); #1;
      drive_in(1'b1, 32'h00E00713, 'h3008);
      bus.out_ready = 1'b1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      drive_in(1'b0, 32'h0, '0);
      @(negedge clk);
      check("fl_out_valid", 64'(bus.out_valid), 64'd0);
      check("fl_in_ready",  64'(bus.in_ready),  64'd1);
      check("fl_state",     64'(dbg_state),     64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("fl_no_capture", 64'(bus.out_valid), 64'd0);
      single("post_flush", 32'h00100793, 3'd1, 'h00000001);

      // Asynchronous reset while an entry is held
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      drive_in(1'b1, 32'h00F00813, 'h4000);
      @(posedge clk); #1;
      drive_in(1'b0, 32'h0, '0);
      @(negedge clk);
      check("ar_loaded", 64'(bus.out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_out_valid", 64'(bus.out_valid), 64'd0);
      check("ar_in_ready",  64'(bus.in_ready),  64'd1);
      check("ar_out_instr", 64'(bus.out_instr), 64'd0);
      check("ar_state",     64'(dbg_state),     64'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      single("post_reset", 32'hFFF00093, 3'd1, 'hFFFFFFFF);

      repeat (2) @(negedge clk);
      check("sb_drain", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
